// File: rtl/fb_port_ctrl.sv
// fb_port_ctrl: responder end of one frame-buffer port. Converts the capture
// controller's active-low write/read requests into single-beat Avalon-MM
// commands that walk a frame linearly from BASE_ADDR. Frame completion is
// reported with one-cycle full / rd_done pulses, and read data is returned
// registered with rd_data_valid.
module fb_port_ctrl #(
   parameter int ADDR_W      = 25,
   parameter int DATA_W      = 32,
   parameter int BASE_ADDR   = 0,
   parameter int FRAME_WORDS = 307200,
   parameter int MAX_OUTST   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic              avl_ready,
   output logic              full,
   output logic              rd_done,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write_req,
   output logic              mem_read_req,
   output logic              mem_burstbegin,
   output logic [2:0]        mem_size,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdata_valid
);

   localparam int PTR_W = $clog2(FRAME_WORDS);
   localparam int OUT_W = $clog2(MAX_OUTST + 1);

   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FRAME_WORDS - 1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUTST);
   localparam logic [OUT_W-1:0]  OUT_ONE  = OUT_W'(1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  ret_ptr_q, ret_ptr_d;
   logic [OUT_W-1:0]  outst_q, outst_d;
   logic              full_q, full_d;
   logic              rd_done_q, rd_done_d;
   logic              rd_data_valid_q, rd_data_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   logic              wr_acc;
   logic              rd_acc;
   logic              rd_ret;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: write wins over read in IDLE; READ waits out in-flight data in DRAIN
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!wr_en) begin
               state_d = ST_WRITE;
            end else if (!rd_en) begin
               state_d = ST_READ;
            end
         end
         ST_WRITE: begin
            if (wr_en) begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (rd_en) begin
               state_d = (outst_d != '0) ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (outst_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Command outputs are combinational so the controller can pop its FIFO on avl_ready
   always_comb begin
      mem_write_req  = reset & ~wr_en & ((state_q == ST_IDLE) | (state_q == ST_WRITE));
      mem_read_req   = reset & ~rd_en & wr_en & ((state_q == ST_IDLE) | (state_q == ST_READ))
                       & (outst_q < OUT_MAX);
      mem_burstbegin = mem_write_req | mem_read_req;
      avl_ready      = reset & mem_ready;
      mem_addr       = BASE + (mem_write_req ? ADDR_W'(wr_ptr_q) : ADDR_W'(rd_ptr_q));
      mem_size       = 3'd1;
      mem_wdata      = wr_data;
   end

   // Pointer, outstanding-count and read-return bookkeeping
   always_comb begin
      wr_acc = mem_write_req & mem_ready;
      rd_acc = mem_read_req & mem_ready;
      // data arriving with nothing outstanding is stale (pre-reset) and is dropped
      rd_ret = mem_rdata_valid & (outst_q != '0);

      wr_ptr_d = wr_ptr_q;
      full_d   = 1'b0;
      if (wr_acc) begin
         if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            full_d   = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
      end

      rd_ptr_d = rd_ptr_q;
      if (rd_acc) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : (rd_ptr_q + PTR_ONE);
      end

      ret_ptr_d       = ret_ptr_q;
      rd_done_d       = 1'b0;
      rd_data_valid_d = 1'b0;
      rd_data_d       = rd_data_q;
      if (rd_ret) begin
         rd_data_valid_d = 1'b1;
         rd_data_d       = mem_rdata;
         if (ret_ptr_q == LAST_PTR) begin
            ret_ptr_d = '0;
            rd_done_d = 1'b1;
         end else begin
            ret_ptr_d = ret_ptr_q + PTR_ONE;
         end
      end

      case ({rd_acc, rd_ret})
         2'b10:   outst_d = outst_q + OUT_ONE;
         2'b01:   outst_d = outst_q - OUT_ONE;
         default: outst_d = outst_q;
      endcase
   end

   // Datapath and status registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         ret_ptr_q       <= '0;
         outst_q         <= '0;
         full_q          <= 1'b0;
         rd_done_q       <= 1'b0;
         rd_data_valid_q <= 1'b0;
         rd_data_q       <= '0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         ret_ptr_q       <= ret_ptr_d;
         outst_q         <= outst_d;
         full_q          <= full_d;
         rd_done_q       <= rd_done_d;
         rd_data_valid_q <= rd_data_valid_d;
         rd_data_q       <= rd_data_d;
      end
   end

   assign full          = full_q;
   assign rd_done       = rd_done_q;
   assign rd_data_valid = rd_data_valid_q;
   assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_fb_port_ctrl.sv
// Bench for fb_port_ctrl with an 8-word frame at base address 100 and at most
// 4 reads outstanding. A memory responder returns read data a fixed number of
// cycles after each accepted read.
module tb_fb_port_ctrl;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 32;
   localparam int BASE   = 100;
   localparam int FW     = 8;
   localparam int MAXO   = 4;

   localparam int M_IDLE  = 0;
   localparam int M_WRITE = 1;
   localparam int M_READ  = 2;
   localparam int M_DRAIN = 3;

   logic              clk;
   logic              reset;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic              avl_ready;
   logic              full;
   logic              rd_done;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write_req;
   logic              mem_read_req;
   logic              mem_burstbegin;
   logic [2:0]        mem_size;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rdata_valid;

   fb_port_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE),
      .FRAME_WORDS(FW), .MAX_OUTST(MAXO)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .avl_ready(avl_ready), .full(full), .rd_done(rd_done), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_write_req(mem_write_req), .mem_read_req(mem_read_req),
      .mem_burstbegin(mem_burstbegin), .mem_size(mem_size), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model
   int          m_mode, m_wr, m_rd, m_ret, m_out;
   logic        e_full, e_done, e_vld;
   logic [31:0] e_data;
   logic [31:0] exp_q[$];
   logic [31:0] fbmem[FW];
   logic        p_wreq, p_rreq;

   // memory responder
   logic        ret_v[16];
   logic [31:0] ret_d[16];
   int          lat;
   logic        spur;
   logic        cap_wreq, cap_rreq;
   int          cap_addr;

   // observation counters
   int obs_vld, obs_done, obs_full, obs_wacc, obs_racc;

   typedef struct {
      logic        wr_en;
      logic        rd_en;
      logic        rdy;
      logic [31:0] wdata;
      logic        e_wreq;
      logic        e_rreq;
      int          e_addr;
      logic        e_full;
   } vec_t;
   vec_t vt[28];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_wr = 0; m_rd = 0; m_ret = 0; m_out = 0;
      e_full = 1'b0; e_done = 1'b0; e_vld = 1'b0; e_data = '0;
      exp_q.delete();
   endtask

   task automatic obs_clear();
      obs_vld = 0; obs_done = 0; obs_full = 0; obs_wacc = 0; obs_racc = 0;
   endtask

   function automatic logic ret_busy();
      for (int i = 0; i < 16; i++) if (ret_v[i]) return 1'b1;
      return 1'b0;
   endfunction

   // just after the negedge: predict and compare, capture the DUT command
   task automatic pre();
      #1;
      p_wreq = reset && !wr_en && (m_mode == M_IDLE || m_mode == M_WRITE);
      p_rreq = reset && !rd_en && wr_en && (m_mode == M_IDLE || m_mode == M_READ) && (m_out < MAXO);
      chk("avl_ready", avl_ready, reset && mem_ready);
      chk("mem_write_req", mem_write_req, p_wreq);
      chk("mem_read_req", mem_read_req, p_rreq);
      chk("mem_burstbegin", mem_burstbegin, p_wreq || p_rreq);
      chk("mem_size", mem_size, 1);
      if (p_wreq || p_rreq) chk("mem_addr", mem_addr, BASE + (p_wreq ? m_wr : m_rd));
      if (p_wreq) chk("mem_wdata", mem_wdata, wr_data);
      chk("full", full, e_full);
      chk("rd_done", rd_done, e_done);
      chk("rd_data_valid", rd_data_valid, e_vld);
      chk("rd_data", rd_data, e_data);
      cap_wreq = mem_write_req;
      cap_rreq = mem_read_req;
      cap_addr = int'(mem_addr);
      if (rd_data_valid) obs_vld++;
      if (rd_done) obs_done++;
      if (full) obs_full++;
      if (cap_wreq && mem_ready) obs_wacc++;
      if (cap_rreq && mem_ready) obs_racc++;
   endtask

   // clock edge: advance model and memory, then drive the return channel
   task automatic post();
      logic wacc, racc, rret;
      int   onew, nmode;
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else begin
         wacc  = p_wreq && mem_ready;
         racc  = p_rreq && mem_ready;
         rret  = mem_rdata_valid && (m_out > 0);
         onew  = m_out + (racc ? 1 : 0) - (rret ? 1 : 0);
         nmode = m_mode;
         case (m_mode)
            M_IDLE:  if (!wr_en) nmode = M_WRITE; else if (!rd_en) nmode = M_READ;
            M_WRITE: if (wr_en) nmode = M_IDLE;
            M_READ:  if (rd_en) nmode = (onew != 0) ? M_DRAIN : M_IDLE;
            M_DRAIN: if (m_out == 0) nmode = M_IDLE;
            default: nmode = M_IDLE;
         endcase
         e_full = wacc && (m_wr == FW - 1);
         if (wacc) m_wr = (m_wr + 1) % FW;
         if (racc) begin
            exp_q.push_back(fbmem[m_rd]);
            m_rd = (m_rd + 1) % FW;
         end
         if (rret) begin
            e_vld  = 1'b1;
            e_done = (m_ret == FW - 1);
            m_ret  = (m_ret + 1) % FW;
            if (exp_q.size() > 0) e_data = exp_q.pop_front();
            else e_data = 'x;
         end else begin
            e_vld  = 1'b0;
            e_done = 1'b0;
         end
         m_out  = onew;
         m_mode = nmode;
      end
      for (int i = 0; i < 15; i++) begin
         ret_v[i] = ret_v[i+1];
         ret_d[i] = ret_d[i+1];
      end
      ret_v[15] = 1'b0;
      if (cap_rreq && mem_ready) begin
         ret_v[lat-1] = 1'b1;
         ret_d[lat-1] = fbmem[(cap_addr - BASE) & (FW - 1)];
      end
      if (cap_wreq && mem_ready) fbmem[(cap_addr - BASE) & (FW - 1)] = wr_data;
      @(negedge clk);
      mem_rdata_valid = ret_v[0] || (spur && m_out == 0);
      mem_rdata       = ret_v[0] ? ret_d[0] : $urandom;
   endtask

   task automatic settle();
      int n;
      n = 0;
      wr_en = 1'b1; rd_en = 1'b1; mem_ready = 1'b1; spur = 1'b0;
      while (!(m_mode == M_IDLE && m_out == 0 && !ret_busy()) && n < 80) begin
         pre(); post(); n++;
      end
      chk("settle_bound", (n < 80), 1);
      pre(); post();
   endtask

   task automatic rand_phase(input int cycles, input int l);
      settle();
      lat = l;
      for (int c = 0; c < cycles; c++) begin
         if ($urandom_range(0, 5) == 0) wr_en = ~wr_en;
         if ($urandom_range(0, 4) == 0) rd_en = ~rd_en;
         mem_ready = ($urandom_range(0, 3) != 0);
         wr_data   = $urandom;
         spur      = ($urandom_range(0, 7) == 0);
         pre(); post();
      end
      settle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, done_at;
      logic seen;

      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; mem_ready = 1'b1;
      wr_data = '0; mem_rdata = '0; mem_rdata_valid = 1'b0;
      spur = 1'b0; lat = 3;
      for (int i = 0; i < 16; i++) begin ret_v[i] = 1'b0; ret_d[i] = '0; end
      for (int i = 0; i < FW; i++) fbmem[i] = '0;
      model_reset();
      obs_clear();

      // vectors: one full frame at ready=1, then one with ready toggling 0,1
      for (int i = 0; i < 8; i++)
         vt[i] = '{1'b0, 1'b1, 1'b1, 32'hA000_0000 + i, 1'b1, 1'b0, BASE + i, 1'b0};
      vt[8] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b1};
      vt[9] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b0};
      for (int k = 0; k < 8; k++) begin
         vt[10+2*k] = '{1'b0, 1'b1, 1'b0, 32'hB000_0000 + k, 1'b1, 1'b0, BASE + k, 1'b0};
         vt[11+2*k] = '{1'b0, 1'b1, 1'b1, 32'hB000_0000 + k, 1'b1, 1'b0, BASE + k, 1'b0};
      end
      vt[26] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b1};
      vt[27] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b0};

      // reset held with both requests low: outputs must stay quiet
      repeat (2) @(posedge clk);
      @(negedge clk);
      pre(); post();
      reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1;

      for (int i = 0; i < 28; i++) begin
         if (i == 10) obs_clear();
         wr_en = vt[i].wr_en; rd_en = vt[i].rd_en; mem_ready = vt[i].rdy; wr_data = vt[i].wdata;
         pre();
         chk("vec_wreq", mem_write_req, vt[i].e_wreq);
         chk("vec_rreq", mem_read_req, vt[i].e_rreq);
         if (vt[i].e_wreq) chk("vec_addr", mem_addr, vt[i].e_addr);
         chk("vec_full", full, vt[i].e_full);
         post();
      end
      chk("t2_accepts", obs_wacc, 8);
      chk("t2_full_pulses", obs_full, 1);

      // frame read, data returning 5 cycles after each command
      settle();
      lat = 5; obs_clear(); done_at = -1; seen = 1'b0; n = 0;
      rd_en = 1'b0;
      while (obs_vld < 8 && n < 80) begin
         if (obs_racc >= 8) rd_en = 1'b1;
         pre();
         if (rd_done && done_at < 0) done_at = obs_vld;
         if (!rd_en && !mem_read_req) seen = 1'b1;
         post(); n++;
      end
      chk("t3_accepts", obs_racc, 8);
      chk("t3_vld_count", obs_vld, 8);
      chk("t3_done_pos", done_at, 8);
      chk("t3_done_count", obs_done, 1);
      chk("t3_throttle", seen, 1);

      // both requests low in IDLE: writes only, reads after wr_en rises
      settle();
      obs_clear();
      wr_en = 1'b0; rd_en = 1'b0;
      for (int c = 0; c < 3; c++) begin wr_data = $urandom; pre(); post(); end
      chk("t4_no_read_while_write", obs_racc, 0);
      chk("t4_writes", obs_wacc, 3);
      wr_en = 1'b1;
      for (int c = 0; c < 4; c++) begin pre(); post(); end
      chk("t4_read_after", (obs_racc > 0), 1);

      // rd_en rises with 3 reads in flight while wr_en falls
      settle();
      lat = 8; obs_clear();
      rd_en = 1'b0;
      for (int c = 0; c < 3; c++) begin pre(); post(); end
      chk("t5_outstanding", obs_racc, 3);
      rd_en = 1'b1; wr_en = 1'b0; wr_data = 32'hC0DE_0005;
      seen = 1'b0; n = 0;
      while (!seen && n < 40) begin
         pre();
         if (mem_write_req) begin
            seen = 1'b1;
            chk("t5_drain_before_write", obs_vld, 3);
         end
         post(); n++;
      end
      chk("t5_write_seen", seen, 1);

      // reset after 5 writes with 2 reads outstanding
      settle();
      lat = 6;
      wr_en = 1'b0;
      for (int c = 0; c < 5; c++) begin wr_data = $urandom; pre(); post(); end
      wr_en = 1'b1;
      pre(); post();
      rd_en = 1'b0; obs_clear();
      for (int c = 0; c < 2; c++) begin pre(); post(); end
      chk("t6_reads_issued", obs_racc, 2);
      reset = 1'b0;
      pre(); post();
      reset = 1'b1; rd_en = 1'b1; obs_clear();
      for (int c = 0; c < 10; c++) begin pre(); post(); end
      chk("t6_no_stale_vld", obs_vld, 0);
      chk("t6_no_full", obs_full, 0);
      wr_en = 1'b0; wr_data = 32'h0000_6666;
      pre();
      chk("t6_wr_ptr_zero", mem_addr, BASE);
      post();
      wr_en = 1'b1;
      pre(); post();
      rd_en = 1'b0;
      pre();
      chk("t6_rd_ptr_zero", mem_addr, BASE);
      post();

      // random traffic against the model
      rand_phase(400, 2);
      rand_phase(400, 5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
